// File: rtl/xgmii_rx_measure.sv
// xgmii_rx_measure: receive-side measurement for the 10G traffic tester.
// Parses the 64-bit XGMII receive stream and delimits frames. Each frame is
// checked for length, control errors, optional FCS and the IPv4 destination
// filter. Accepted frames and bytes are accumulated per measurement window.
//
// Ports:
//   sys_clk, sys_rst_n   clock, async active-low reset
//   xgmii_rxd/rxc        64-bit data / 8-bit control, lane 0 first on the wire
//   rx_enable            measurement enable (0 holds the parser idle)
//   rx_ipv4_dstip        destination IP filter, 0 = accept any
//   rx_frame_valid       one-cycle pulse per accepted frame
//   rx_frame_len         length of the last accepted frame (incl. FCS)
//   rx_total_frames      all delimited frames
//   rx_err_frames        runt / oversize / control-error / FCS-error frames
//   rx_pps               accepted frames in the last completed window
//   rx_throughput        accepted bytes in the last completed window
//
// Build option: define RX_CRC_CHECK_EN to build the CRC-32 FCS checker.
module xgmii_rx_measure #(
    parameter int unsigned ONE_SEC_CYCLES = 156_250_000,
    parameter int unsigned MAX_FRAME_LEN  = 1518
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    input  logic        rx_enable,
    input  logic [31:0] rx_ipv4_dstip,
    output logic        rx_frame_valid,
    output logic [15:0] rx_frame_len,
    output logic [31:0] rx_total_frames,
    output logic [31:0] rx_err_frames,
    output logic [31:0] rx_pps,
    output logic [31:0] rx_throughput
);

    localparam int unsigned LEN_W     = 16;
    localparam int unsigned LEN_SUM_W = LEN_W + 1;
    localparam int unsigned CNT_W     = 32;
    localparam int unsigned ACC_SUM_W = CNT_W + 1;
    localparam int unsigned WIDX_W    = 3;
    localparam logic [63:0] START_WORD = 64'hD5555555555555FB;

    typedef enum logic [1:0] {IDLE, DATA, EVAL} state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                ctl_err_q, ctl_err_d;
    logic [WIDX_W-1:0]   widx_q, widx_d;
    logic [15:0]         etype_q, etype_d;
    logic [31:0]         dstip_q, dstip_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [31:0]         acc_frames_q, acc_bytes_q;
    logic [31:0]         acc_frames_d, acc_bytes_d;

    logic                start_c, term_hit_c, ctl_bad_c;
    logic [3:0]          term_lane_c;
    logic [LEN_SUM_W-1:0] len_sum_c;
    logic                eval_c, err_c, match_c, accept_c, fcs_err_c, wrap_c;
    logic [ACC_SUM_W-1:0] frames_sum_c, bytes_sum_c;

`ifdef RX_CRC_CHECK_EN
    logic [31:0] crc_q, crc_d;

    // Reflected CRC-32 over the first n lanes of a word.
    function automatic logic [31:0] crc_lanes(input logic [31:0] crc,
                                              input logic [63:0] d,
                                              input logic [3:0]  n);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int j = 0; j < 8; j++) begin
            if (4'(j) < n) begin
                for (int b = 0; b < 8; b++) begin
                    fb = c[0] ^ d[8*j+b];
                    c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
                end
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] bit_rev(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    // Register holds the residue in reflected bit order.
    assign fcs_err_c = (bit_rev(crc_q) != 32'hC704DD7B);
`else
    assign fcs_err_c = 1'b0;
`endif

    assign start_c = (xgmii_rxc == 8'h01) && (xgmii_rxd == START_WORD);

    // Find the first terminate lane; any other control before it is an error.
    always_comb begin : lane_scan
        term_hit_c  = 1'b0;
        term_lane_c = 4'd8;
        ctl_bad_c   = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (!term_hit_c && xgmii_rxc[j]) begin
                if (xgmii_rxd[8*j +: 8] == 8'hFD) begin
                    term_hit_c  = 1'b1;
                    term_lane_c = 4'(j);
                end else begin
                    ctl_bad_c = 1'b1;
                end
            end
        end
    end

    assign len_sum_c = {1'b0, len_q} + LEN_SUM_W'(term_lane_c);

    // Next-state and frame capture.
    always_comb begin : fsm_next
        state_d   = state_q;
        len_d     = len_q;
        ctl_err_d = ctl_err_q;
        widx_d    = widx_q;
        etype_d   = etype_q;
        dstip_d   = dstip_q;
`ifdef RX_CRC_CHECK_EN
        crc_d     = crc_q;
`endif
        case (state_q)
            IDLE, EVAL: state_d = start_c ? DATA : IDLE;
            DATA: begin
                len_d     = len_sum_c[LEN_W] ? '1 : len_sum_c[LEN_W-1:0];
                ctl_err_d = ctl_err_q | ctl_bad_c;
                if (widx_q == WIDX_W'(1)) etype_d = {xgmii_rxd[39:32], xgmii_rxd[47:40]};
                if (widx_q == WIDX_W'(3)) dstip_d[31:16] = {xgmii_rxd[55:48], xgmii_rxd[63:56]};
                if (widx_q == WIDX_W'(4)) dstip_d[15:0]  = {xgmii_rxd[7:0], xgmii_rxd[15:8]};
                if (widx_q != '1) widx_d = widx_q + WIDX_W'(1);
`ifdef RX_CRC_CHECK_EN
                crc_d = crc_lanes(crc_q, xgmii_rxd, term_lane_c);
`endif
                if (term_hit_c) state_d = EVAL;
            end
            default: state_d = IDLE;
        endcase
        // A start word in DATA is only a control error; it never restarts.
        if ((state_q != DATA) && start_c) begin
            len_d     = '0;
            ctl_err_d = 1'b0;
            widx_d    = '0;
            etype_d   = '0;
            dstip_d   = '0;
`ifdef RX_CRC_CHECK_EN
            crc_d     = 32'hFFFFFFFF;
`endif
        end
        if (!rx_enable) state_d = IDLE;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin : fsm_reg
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            ctl_err_q <= 1'b0;
            widx_q    <= '0;
            etype_q   <= '0;
            dstip_q   <= '0;
`ifdef RX_CRC_CHECK_EN
            crc_q     <= 32'hFFFFFFFF;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            ctl_err_q <= ctl_err_d;
            widx_q    <= widx_d;
            etype_q   <= etype_d;
            dstip_q   <= dstip_d;
`ifdef RX_CRC_CHECK_EN
            crc_q     <= crc_d;
`endif
        end
    end

    // Frame classification during EVAL.
    assign eval_c   = (state_q == EVAL) && rx_enable;
    assign err_c    = (len_q < LEN_W'(64)) || (len_q > LEN_W'(MAX_FRAME_LEN)) ||
                      ctl_err_q || fcs_err_c;
    assign match_c  = (etype_q == 16'h0800) &&
                      ((rx_ipv4_dstip == 32'h0) || (dstip_q == rx_ipv4_dstip));
    assign accept_c = eval_c && !err_c && match_c;

    // Window accumulators include a frame accepted on the wrap cycle.
    assign wrap_c       = (cnt_q == CNT_W'(ONE_SEC_CYCLES - 1));
    assign frames_sum_c = {1'b0, acc_frames_q} + ACC_SUM_W'(accept_c);
    assign bytes_sum_c  = {1'b0, acc_bytes_q} + (accept_c ? ACC_SUM_W'(len_q) : '0);
    assign acc_frames_d = frames_sum_c[CNT_W] ? '1 : frames_sum_c[CNT_W-1:0];
    assign acc_bytes_d  = bytes_sum_c[CNT_W]  ? '1 : bytes_sum_c[CNT_W-1:0];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin : stats_reg
        if (!sys_rst_n) begin
            rx_frame_valid  <= 1'b0;
            rx_frame_len    <= '0;
            rx_total_frames <= '0;
            rx_err_frames   <= '0;
            rx_pps          <= '0;
            rx_throughput   <= '0;
            cnt_q           <= '0;
            acc_frames_q    <= '0;
            acc_bytes_q     <= '0;
        end else begin
            rx_frame_valid <= accept_c;
            if (accept_c) rx_frame_len <= len_q;
            if (eval_c) rx_total_frames <= rx_total_frames + 32'd1;
            if (eval_c && err_c) rx_err_frames <= rx_err_frames + 32'd1;
            if (wrap_c) begin
                cnt_q         <= '0;
                rx_pps        <= acc_frames_d;
                rx_throughput <= acc_bytes_d;
                acc_frames_q  <= '0;
                acc_bytes_q   <= '0;
            end else begin
                cnt_q        <= cnt_q + CNT_W'(1);
                acc_frames_q <= acc_frames_d;
                acc_bytes_q  <= acc_bytes_d;
            end
        end
    end

endmodule

// File: tb/tb_xgmii_rx_measure.sv
// Scoreboard bench for xgmii_rx_measure: stimulus pushes expected frame
// lengths and output snapshots; one monitor process compares them.
module tb_xgmii_rx_measure;

`ifdef RX_CRC_CHECK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic        rx_enable;
    logic [31:0] rx_ipv4_dstip;
    logic        rx_frame_valid;
    logic [15:0] rx_frame_len;
    logic [31:0] rx_total_frames, rx_err_frames, rx_pps, rx_throughput;

    always #5 sys_clk = ~sys_clk;

    xgmii_rx_measure #(.ONE_SEC_CYCLES(100), .MAX_FRAME_LEN(1518)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
        .rx_enable(rx_enable), .rx_ipv4_dstip(rx_ipv4_dstip),
        .rx_frame_valid(rx_frame_valid), .rx_frame_len(rx_frame_len),
        .rx_total_frames(rx_total_frames), .rx_err_frames(rx_err_frames),
        .rx_pps(rx_pps), .rx_throughput(rx_throughput)
    );

    typedef enum int {S_VALID, S_LEN, S_TOTAL, S_ERR, S_PPS, S_TPUT, S_END} sel_e;
    typedef struct {
        sel_e        sel;
        logic [31:0] exp;
    } snap_t;

    snap_t       snap_q[$];
    logic [15:0] exp_len_q[$];
    logic [7:0]  frm[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned edges = 0;
    int unsigned base  = 0;
    logic [31:0] exp_total = 0, exp_err = 0, exp_last_len = 0;

    localparam logic [31:0] IP_102 = 32'hC0A80266;
    localparam logic [31:0] IP_103 = 32'hC0A80267;

    always @(posedge sys_clk) edges <= edges + 1;

    // Monitor: checks frame pulses and pending snapshots after each edge.
    snap_t       mon_s;
    logic [31:0] mon_act;
    logic [15:0] mon_e;
    string       mon_nm;
    always begin
        @(posedge sys_clk);
        #1;
        if (sys_rst_n && rx_frame_valid) begin
            tests++;
            if (exp_len_q.size() == 0) begin
                fails++;
                $display("FAIL frame_pulse: unexpected pulse with len=%0d, required no pulse", rx_frame_len);
            end else begin
                mon_e = exp_len_q.pop_front();
                if (rx_frame_len !== mon_e) begin
                    fails++;
                    $display("FAIL frame_len_at_pulse: got %0d, required %0d", rx_frame_len, mon_e);
                end
            end
        end
        while (snap_q.size() != 0) begin
            mon_s = snap_q.pop_front();
            case (mon_s.sel)
                S_VALID: begin mon_act = 32'(rx_frame_valid); mon_nm = "rx_frame_valid"; end
                S_LEN:   begin mon_act = 32'(rx_frame_len);   mon_nm = "rx_frame_len"; end
                S_TOTAL: begin mon_act = rx_total_frames;     mon_nm = "rx_total_frames"; end
                S_ERR:   begin mon_act = rx_err_frames;       mon_nm = "rx_err_frames"; end
                S_PPS:   begin mon_act = rx_pps;              mon_nm = "rx_pps"; end
                S_TPUT:  begin mon_act = rx_throughput;       mon_nm = "rx_throughput"; end
                default: begin mon_act = 32'(exp_len_q.size()); mon_nm = "missing_frame_pulses"; end
            endcase
            tests++;
            if (mon_act !== mon_s.exp) begin
                fails++;
                $display("FAIL %s: got %0d, required %0d", mon_nm, mon_act, mon_s.exp);
            end
            if (mon_s.sel == S_END) begin
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: end of test not reached, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic push_snap(input sel_e s, input logic [31:0] v);
        snap_t t;
        t.sel = s;
        t.exp = v;
        snap_q.push_back(t);
    endtask

    task automatic drive(input logic [63:0] d, input logic [7:0] c);
        xgmii_rxd = d;
        xgmii_rxc = c;
        @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(64'h0707070707070707, 8'hFF);
    endtask

    // Frame bytes with header fields and FCS appended LSB first.
    task automatic build(input int len, input logic [31:0] ip, input logic [15:0] et, input bit corrupt);
        logic [31:0] crc;
        frm.delete();
        for (int i = 0; i < len; i++) begin
            case (i)
                12: frm.push_back(et[15:8]);
                13: frm.push_back(et[7:0]);
                14: frm.push_back(8'h45);
                30: frm.push_back(ip[31:24]);
                31: frm.push_back(ip[23:16]);
                32: frm.push_back(ip[15:8]);
                33: frm.push_back(ip[7:0]);
                default: frm.push_back(8'(i * 7 + 3));
            endcase
        end
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < len - 4; i++) crc = crc32_byte(crc, frm[i]);
        crc = ~crc;
        frm[len-4] = crc[7:0];
        frm[len-3] = crc[15:8];
        frm[len-2] = crc[23:16];
        frm[len-1] = crc[31:24];
        if (corrupt) frm[63] = frm[63] ^ 8'h01;
    endtask

    task automatic send(input bit bad_pre, input bit inject);
        logic [63:0] d;
        logic [7:0]  c;
        int          n;
        n = frm.size();
        drive(bad_pre ? 64'hD5545555555555FB : 64'hD5555555555555FB, 8'h01);
        for (int w = 0; w <= n / 8; w++) begin
            for (int l = 0; l < 8; l++) begin
                int idx;
                idx = 8 * w + l;
                if (idx < n)       begin d[8*l +: 8] = frm[idx]; c[l] = 1'b0; end
                else if (idx == n) begin d[8*l +: 8] = 8'hFD;    c[l] = 1'b1; end
                else               begin d[8*l +: 8] = 8'h07;    c[l] = 1'b1; end
            end
            if (inject && w == 2) begin
                d[31:24] = 8'h07;
                c[3]     = 1'b1;
            end
            drive(d, c);
        end
    endtask

    task automatic run_frame(input int len, input logic [31:0] ip, input logic [15:0] et,
                             input logic [31:0] filter, input bit corrupt, input bit inject,
                             input bit bad_pre, input bit accept, input bit is_err, input bit counted);
        rx_ipv4_dstip = filter;
        build(len, ip, et, corrupt);
        if (accept) begin
            exp_len_q.push_back(16'(len));
            exp_last_len = 32'(len);
        end
        send(bad_pre, inject);
        idle(4);
        if (counted) exp_total = exp_total + 1;
        if (is_err)  exp_err = exp_err + 1;
        push_snap(S_TOTAL, exp_total);
        push_snap(S_ERR, exp_err);
        push_snap(S_LEN, exp_last_len);
        idle(2);
    endtask

    initial begin
        sys_rst_n     = 1'b1;
        rx_enable     = 1'b1;
        rx_ipv4_dstip = IP_102;
        xgmii_rxd     = 64'h0707070707070707;
        xgmii_rxc     = 8'hFF;
        #2 sys_rst_n  = 1'b0;
        push_snap(S_VALID, 0); push_snap(S_LEN, 0); push_snap(S_TOTAL, 0);
        push_snap(S_ERR, 0);   push_snap(S_PPS, 0); push_snap(S_TPUT, 0);
        @(negedge sys_clk);
        idle(2);
        sys_rst_n = 1'b1;
        idle(2);

        //        len   ip      etype     filter  crpt inj  bpre acc       err      cnt
        run_frame(64,   IP_102, 16'h0800, IP_102, 0,   0,   0,   1,        0,       1);
        run_frame(64,   IP_102, 16'h0800, IP_102, 1,   0,   0,   !CRC_ON,  CRC_ON,  1);
        run_frame(60,   IP_102, 16'h0800, IP_102, 0,   0,   0,   0,        1,       1);
        run_frame(1600, IP_102, 16'h0800, IP_102, 0,   0,   0,   0,        1,       1);
        run_frame(64,   IP_102, 16'h0800, IP_102, 0,   1,   0,   0,        1,       1);
        run_frame(64,   IP_103, 16'h0800, IP_102, 0,   0,   0,   0,        0,       1);
        run_frame(64,   IP_103, 16'h0800, 32'h0,  0,   0,   0,   1,        0,       1);
        run_frame(65,   IP_102, 16'h0800, 32'h0,  0,   0,   0,   1,        0,       1);
        run_frame(1518, IP_102, 16'h0800, IP_102, 0,   0,   0,   1,        0,       1);
        run_frame(64,   IP_102, 16'h0800, IP_102, 0,   0,   1,   0,        0,       0);
        rx_enable = 1'b0;
        run_frame(64,   IP_102, 16'h0800, IP_102, 0,   0,   0,   0,        0,       0);
        rx_enable = 1'b1;
        run_frame(64,   IP_102, 16'h86DD, IP_102, 0,   0,   0,   0,        0,       1);

        // Reset in the middle of a frame clears every output at once.
        rx_ipv4_dstip = IP_102;
        build(64, IP_102, 16'h0800, 1'b0);
        drive(64'hD5555555555555FB, 8'h01);
        for (int w = 0; w < 3; w++)
            drive({frm[8*w+7], frm[8*w+6], frm[8*w+5], frm[8*w+4],
                   frm[8*w+3], frm[8*w+2], frm[8*w+1], frm[8*w]}, 8'h00);
        sys_rst_n = 1'b0;
        push_snap(S_VALID, 0); push_snap(S_LEN, 0); push_snap(S_TOTAL, 0);
        push_snap(S_ERR, 0);   push_snap(S_PPS, 0); push_snap(S_TPUT, 0);
        idle(2);
        sys_rst_n    = 1'b1;
        exp_total    = 0;
        exp_err      = 0;
        exp_last_len = 0;
        run_frame(64, IP_102, 16'h0800, IP_102, 0, 0, 0, 1, 0, 1);

        // Window: three back-to-back frames in window 1, none in window 2.
        sys_rst_n = 1'b0;
        idle(1);
        sys_rst_n = 1'b1;
        base      = edges;
        build(64, IP_102, 16'h0800, 1'b0);
        repeat (3) begin
            exp_len_q.push_back(16'd64);
            send(1'b0, 1'b0);
        end
        while (edges - base < 99) idle(1);
        push_snap(S_PPS, 3);
        push_snap(S_TPUT, 192);
        push_snap(S_TOTAL, 3);
        while (edges - base < 199) idle(1);
        push_snap(S_PPS, 0);
        push_snap(S_TPUT, 0);
        idle(2);
        push_snap(S_END, 0);
        idle(5);
    end

endmodule

// File: doc/xgmii_rx_measure.md
# xgmii_rx_measure

Receive-side measurement block for the 10G traffic tester. It parses the 64-bit XGMII receive stream coming back from the link, delimits Ethernet frames, and checks length, FCS and the IPv4 destination filter. It accumulates per-window frame and byte rates, which are the receive-side counterpart of the transmitter's `tx0_pps`/`tx0_throughput`. Outputs feed the PCI user register file.

## Interface
Parameters:
- `ONE_SEC_CYCLES`, 156_250_000, measurement window length in `sys_clk` cycles.
- `MAX_FRAME_LEN`, 1518, largest legal frame in bytes (dst MAC through FCS).

Ports:
- `sys_clk`  in  1  156.25 MHz XGMII clock; the block's only clock.
- `sys_rst_n`  in  1  reset, asynchronous assert, active-low.
- `xgmii_rxd`  in  64  receive data; lane i = bits [8i+7:8i]; lane 0 is first on the wire.
- `xgmii_rxc`  in  8  receive control; bit i = 1 marks lane i as a control character.
- `rx_enable`  in  1  measurement enable.
- `rx_ipv4_dstip`  in  32  destination IP filter; 0 accepts any IPv4 address.
- `rx_frame_valid`  out  1  one-cycle pulse per accepted frame.
- `rx_frame_len`  out  16  length of the last accepted frame, including FCS.
- `rx_total_frames`  out  32  all delimited frames; wraps mod 2^32.
- `rx_err_frames`  out  32  runt, oversize, control-error or FCS-error frames; wraps mod 2^32.
- `rx_pps`  out  32  accepted frames in the last completed window.
- `rx_throughput`  out  32  accepted bytes in the last completed window.

## Operation
- FSM states: IDLE, DATA, EVAL.
- **IDLE -> DATA** only on a valid start word:
  - lane 0 = 0xFB with rxc[0] = 1;
  - lanes 1-6 = 0x55 data;
  - lane 7 = 0xD5 data.
  - A start character in lane 4 is ignored.
  - A malformed preamble stays in IDLE and is not counted.
- **Frame byte positions:** frame byte b is in the (b/8 + 1)th word after the start word, lane b%8.
- **Captured header fields:**
  - EtherType from bytes 12-13: word 1, lanes 4-5.
  - IPv4 destination from bytes 30-33: word 3 lanes 6-7, then word 4 lanes 0-1.
- **DATA:** each word adds its data lanes to a 16-bit saturating byte count. Lanes are counted up to the first lane with rxc = 1 and value 0xFD (terminate); that word then moves the FSM to EVAL.
  - Any other control character before the terminate sets `ctl_err`.
  - The frame continues to the terminate.
- **EVAL** (one cycle, then back to IDLE). The frame is:
  - **error** if len < 64, len > MAX_FRAME_LEN, `ctl_err` is set, or the FCS is bad;
  - **accepted** if not an error, EtherType = 0x0800, and (filter = 0 or captured dst IP = filter);
  - **ignored** otherwise: counted in total only.
- `rx_total_frames` increments for every frame reaching EVAL.
- **`rx_enable` = 0:** the FSM is held in IDLE and any frame in progress is discarded uncounted. The window timer keeps running.
- **Window:**
  - The cycle counter runs 0..ONE_SEC_CYCLES-1.
  - On the wrap cycle, `rx_pps`/`rx_throughput` load the window accumulators and the accumulators clear.
  - A frame accepted on the wrap cycle is included in the closing window.
  - Accumulators saturate at 0xFFFFFFFF.

## Timing
- Reset: every output = 0, FSM = IDLE, window counter = 0, accumulators = 0. Reset takes effect immediately, including mid-frame.
- `rx_frame_valid` and the counter updates occur 2 cycles after the terminate word, in both configurations.
- `rx_frame_len` is updated in the same cycle as the pulse and holds until the next accepted frame.
- Back-to-back frames: a start word may arrive in the cycle after the terminate word and must be accepted. EVAL overlaps the next frame's start word.
- A start word arriving while in DATA is a control error for the current frame; the new frame is not started.

## Configuration
- `RX_CRC_CHECK_EN` defined:
  - CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) runs over bytes 0..len-1, 8 lanes per cycle.
  - Residue ≠ 0xC704DD7B marks an FCS error.
- Undefined: no CRC logic is built and the FCS is never checked.

## Test plan
- 64-byte IPv4 frame, dst 192.168.2.102, filter 0xC0A80266, good FCS -> one `rx_frame_valid` pulse, `rx_frame_len` = 64, total = 1, err = 0.
- Same frame with FCS byte 63 XOR 0x01 -> with the macro: err = 1, no pulse. Without the macro: pulse, err = 0.
- 60-byte frame; separately a 1600-byte frame; separately 0x07 control in lane 3 mid-frame -> err increments by 1 each, no pulses.
- dst 192.168.2.103, filter 0xC0A80266 -> total +1, no pulse, err unchanged. Repeat with filter 0 -> pulse.
- ONE_SEC_CYCLES = 100, three back-to-back 64-byte frames in window 1, none in window 2 -> `rx_pps` = 3 and `rx_throughput` = 192 after cycle 100; both 0 after cycle 200.
- `sys_rst_n` low mid-frame -> all outputs 0 in that cycle. After release, the next frame is counted normally with total = 1.
